// File: rtl/logic_gate_unit.sv
// Registered bitwise gate unit with valid/ready handshakes, single-beat or
// packet-folding (OR/AND/XOR) operation and reduction flags on the result.
module logic_gate_unit #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 15,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_red_or,
  output logic             out_red_and,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_trunc
);

  // state | meaning
  // IDLE  | no packet open; next beat is single or starts a packet
  // ACC   | packet open; acc_q/cnt_q hold the partial fold
  typedef enum logic {IDLE, ACC} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic             red_or_q, red_or_d;
  logic             red_and_q, red_and_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic             trunc_q, trunc_d;

  logic             accept;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] cnt_inc;
  logic             emit;
  logic [WIDTH-1:0] emit_val;
  logic [CNT_W-1:0] emit_cnt;
  logic             emit_trunc;

  // The output register frees in the same cycle it is drained.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    case (in_op)
      3'd0:    r = in_a & in_b;
      3'd1:    r = in_a | in_b;
      3'd2:    r = in_a ^ in_b;
      3'd3:    r = ~(in_a & in_b);
      3'd4:    r = ~(in_a | in_b);
      3'd5:    r = ~(in_a ^ in_b);
      3'd6:    r = ~in_a;
      default: r = in_a;
    endcase
  end

  always_comb begin
    case (mode_q)
      2'd1:    fold = acc_q | r;
      2'd2:    fold = acc_q & r;
      default: fold = acc_q ^ r;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    red_or_d    = red_or_q;
    red_and_d   = red_and_q;
    out_beats_d = out_beats_q;
    trunc_d     = trunc_q;
    emit        = 1'b0;
    emit_val    = r;
    emit_cnt    = CNT_W'(1);
    emit_trunc  = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_mode == 2'd0) begin
            emit = 1'b1;
          end else begin
            mode_d = in_mode;
            if (in_last) begin
              emit = 1'b1;
            end else begin
              acc_d   = r;
              cnt_d   = CNT_W'(1);
              state_d = ACC;
            end
          end
        end
        default: begin
          emit_val = fold;
          emit_cnt = cnt_inc;
          if (in_last) begin
            emit = 1'b1;
          end else if (cnt_inc == MAX_CNT) begin
            emit       = 1'b1;
            emit_trunc = 1'b1;
          end else begin
            acc_d = fold;
            cnt_d = cnt_inc;
          end
        end
      endcase
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_c_d     = emit_val;
      red_or_d    = |emit_val;
      red_and_d   = &emit_val;
      out_beats_d = emit_cnt;
      trunc_d     = emit_trunc;
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= 2'd0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      red_or_q    <= 1'b0;
      red_and_q   <= 1'b0;
      out_beats_q <= '0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      red_or_q    <= red_or_d;
      red_and_q   <= red_and_d;
      out_beats_q <= out_beats_d;
      trunc_q     <= trunc_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_c       = out_c_q;
  assign out_red_or  = red_or_q;
  assign out_red_and = red_and_q;
  assign out_beats   = out_beats_q;
  assign out_trunc   = trunc_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: directed scenarios then a randomized stream,
// all checked against a packet-level reference model.
module tb_logic_gate_unit;

  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 15;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic [1:0]       in_mode = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_c;
  logic             out_red_or;
  logic             out_red_and;
  logic [CNT_W-1:0] out_beats;
  logic             out_trunc;

  logic_gate_unit #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_red_or(out_red_or), .out_red_and(out_red_and),
    .out_beats(out_beats), .out_trunc(out_trunc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: expected output register plus the list of beat results
  // of the currently open packet.
  logic             m_v = 1'b0;
  logic [WIDTH-1:0] m_c = '0;
  int               m_beats = 0;
  logic             m_trunc = 1'b0;
  logic [WIDTH-1:0] pkt[$];
  logic [1:0]       pmode = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] gate(input logic [WIDTH-1:0] a, b, input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic emit(input logic trunc);
    logic [WIDTH-1:0] v;
    v = pkt[0];
    for (int i = 1; i < pkt.size(); i++) begin
      if (pmode == 2'd1) v = v | pkt[i];
      else if (pmode == 2'd2) v = v & pkt[i];
      else v = v ^ pkt[i];
    end
    m_v = 1'b1; m_c = v; m_beats = pkt.size(); m_trunc = trunc;
    pkt.delete();
  endtask

  task automatic model_beat(input logic [WIDTH-1:0] a, b, input logic [2:0] op,
                            input logic [1:0] mode, input logic last);
    if (pkt.size() == 0) pmode = mode;
    pkt.push_back(gate(a, b, op));
    if (pmode == 2'd0) emit(1'b0);
    else if (last) emit(1'b0);
    else if (pkt.size() == MAX_BEATS) emit(1'b1);
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_v));
    if (m_v) begin
      chk({tag, ".c"}, 32'(out_c), 32'(m_c));
      chk({tag, ".red_or"}, 32'(out_red_or), 32'(|m_c));
      chk({tag, ".red_and"}, 32'(out_red_and), 32'(&m_c));
      chk({tag, ".beats"}, 32'(out_beats), 32'(m_beats));
      chk({tag, ".trunc"}, 32'(out_trunc), 32'(m_trunc));
    end
  endtask

  // One clock: check in_ready, let the edge happen, advance the model, check outputs.
  task automatic tick(input string tag);
    logic exp_ready, acc_ok, pop;
    logic [WIDTH-1:0] a, b;
    logic [2:0] op;
    logic [1:0] mode;
    logic last;
    #1;
    exp_ready = !m_v || out_ready;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    acc_ok = in_valid && exp_ready;
    pop = m_v && out_ready;
    a = in_a; b = in_b; op = in_op; mode = in_mode; last = in_last;
    @(posedge clk); #1;
    if (pop) m_v = 1'b0;
    if (acc_ok) model_beat(a, b, op, mode, last);
    chk_out(tag);
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, b,
                       input logic [2:0] op, input logic [1:0] mode, input logic last);
    in_valid = v; in_a = a; in_b = b; in_op = op; in_mode = mode; in_last = last;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, ".valid"}, 32'(out_valid), 0);
    chk({tag, ".c"}, 32'(out_c), 0);
    chk({tag, ".red_or"}, 32'(out_red_or), 0);
    chk({tag, ".red_and"}, 32'(out_red_and), 0);
    chk({tag, ".beats"}, 32'(out_beats), 0);
    chk({tag, ".trunc"}, 32'(out_trunc), 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
    m_v = 1'b0;
    pkt.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [WIDTH-1:0] t2_exp [8];
  logic [WIDTH-1:0] snap_c;

  initial begin
    t2_exp = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};

    // 1: reset held while a stream is being offered
    @(posedge clk); #1;
    drive(1'b1, 8'h5A, 8'hA5, 3'd2, 2'd0, 1'b0);
    do_reset("t1_reset");
    drive(1'b0, '0, '0, 3'd0, 2'd0, 1'b0);
    tick("t1_idle");

    // 2: single-mode op sweep
    for (int op = 0; op < 8; op++) begin
      drive(1'b1, 8'hF0, 8'h3C, 3'(op), 2'd0, 1'b0);
      tick("t2_sweep");
      chk("t2_const_c", 32'(out_c), 32'(t2_exp[op]));
      chk("t2_const_beats", 32'(out_beats), 1);
    end
    drive(1'b0, '0, '0, 3'd0, 2'd0, 1'b0);
    tick("t2_drain");

    // 3: acc-OR packet of three PASS beats
    drive(1'b1, 8'h01, 8'h00, 3'd7, 2'd1, 1'b0); tick("t3_b1");
    chk("t3_no_out1", 32'(out_valid), 0);
    drive(1'b1, 8'h02, 8'h00, 3'd7, 2'd1, 1'b0); tick("t3_b2");
    chk("t3_no_out2", 32'(out_valid), 0);
    drive(1'b1, 8'h04, 8'h00, 3'd7, 2'd1, 1'b1); tick("t3_b3");
    chk("t3_const_c", 32'(out_c), 32'h07);
    chk("t3_const_beats", 32'(out_beats), 3);
    chk("t3_const_flags", {30'd0, out_red_or, out_red_and}, 32'b10);
    chk("t3_const_trunc", 32'(out_trunc), 0);
    drive(1'b0, '0, '0, 3'd0, 2'd0, 1'b0); tick("t3_drain");

    // 4: acc-XOR truncation at MAX_BEATS, then a fresh packet
    for (int i = 0; i < MAX_BEATS; i++) begin
      drive(1'b1, 8'hFF, 8'h00, 3'd7, 2'd3, 1'b0);
      tick("t4_beat");
    end
    chk("t4_const_valid", 32'(out_valid), 1);
    chk("t4_const_c", 32'(out_c), 32'hFF);
    chk("t4_const_beats", 32'(out_beats), MAX_BEATS);
    chk("t4_const_trunc", 32'(out_trunc), 1);
    drive(1'b1, 8'h3C, 8'h00, 3'd7, 2'd3, 1'b1); tick("t4_new");
    chk("t4_new_beats", 32'(out_beats), 1);
    chk("t4_new_trunc", 32'(out_trunc), 0);
    drive(1'b0, '0, '0, 3'd0, 2'd0, 1'b0); tick("t4_drain");

    // 5: backpressure
    out_ready = 1'b0;
    drive(1'b1, 8'h0F, 8'hFF, 3'd0, 2'd0, 1'b0); tick("t5_load");
    snap_c = out_c;
    drive(1'b1, 8'h11, 8'h22, 3'd1, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick("t5_hold");
      chk("t5_stable", 32'(out_c), 32'(snap_c));
    end
    out_ready = 1'b1;
    tick("t5_release");
    chk("t5_next_c", 32'(out_c), 32'h33);
    drive(1'b0, '0, '0, 3'd0, 2'd0, 1'b0); tick("t5_drain");

    // 6: reset in the middle of an acc-AND packet
    drive(1'b1, 8'hFF, 8'hF0, 3'd0, 2'd2, 1'b0); tick("t6_b1");
    drive(1'b1, 8'hFF, 8'h0F, 3'd1, 2'd2, 1'b0); tick("t6_b2");
    do_reset("t6_reset");
    drive(1'b0, '0, '0, 3'd0, 2'd0, 1'b0); tick("t6_idle");
    chk("t6_no_out", 32'(out_valid), 0);
    drive(1'b1, 8'hAA, 8'hFF, 3'd0, 2'd0, 1'b0); tick("t6_single");
    chk("t6_const_c", 32'(out_c), 32'hAA);
    chk("t6_const_beats", 32'(out_beats), 1);

    // Randomized stream with random backpressure and packet lengths
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom),
            3'($urandom), 2'($urandom), 1'($urandom_range(0, 5) == 0));
      out_ready = 1'($urandom_range(0, 3) != 0);
      tick("rand");
    end
    drive(1'b0, '0, '0, 3'd0, 2'd0, 1'b0);
    out_ready = 1'b1;
    tick("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
